// File: rtl/avalon_pio_edge_pkg.sv
// pio_pkg: register addresses and edge-capture modes shared by the PIO block
package pio_pkg;
  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/avalon_pio_edge_if.sv
// avalon_pio_edge_if: Avalon-MM slave register bus with active-low strobes
interface avalon_pio_edge_if #(parameter int WIDTH = 8) ();
  logic [2:0]       address;
  logic             chipselect;
  logic             read_n;
  logic             write_n;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] readdata;
  modport master (output address, chipselect, read_n, write_n, writedata, input readdata);
  modport slave (input address, chipselect, read_n, write_n, writedata, output readdata);
endinterface

// File: rtl/avalon_pio_edge_detect.sv
// pio_edge_detect: two-flop input synchroniser plus delayed copy for per-bit edge pulses
module pio_edge_detect
  import pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] edge_pulse
);
  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] in_prev;
  always_ff @(posedge clk) begin
    if (reset) begin
      meta    <= '0;
      in_sync <= '0;
      in_prev <= '0;
    end else begin
      meta    <= in_port;
      in_sync <= meta;
      in_prev <= in_sync;
    end
  end
  assign edge_pulse = EDGE_TYPE == EDGE_RISE ? in_sync & ~in_prev :
                      EDGE_TYPE == EDGE_FALL ? ~in_sync & in_prev :
                                               in_sync ^ in_prev;
endmodule

// File: rtl/avalon_pio_edge.sv
// avalon_pio_edge: Avalon-MM PIO with per-bit direction, set/clear, edge capture and maskable irq
module avalon_pio_edge
  import pio_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_OUT = '0,
  parameter logic [WIDTH-1:0] RESET_DIR = '1,
  parameter int               EDGE_TYPE = EDGE_RISE
) (
  input  logic                clk,
  input  logic                reset,
  avalon_pio_edge_if.slave    bus,
  input  logic [WIDTH-1:0]    in_port,
  output logic [WIDTH-1:0]    out_port,
  output logic [WIDTH-1:0]    oe_port,
  output logic                irq
);
  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] rd_mux;
  pio_edge_detect #(.WIDTH(WIDTH), .EDGE_TYPE(EDGE_TYPE)) u_detect (
    .clk        (clk),
    .reset      (reset),
    .in_port    (in_port),
    .in_sync    (in_sync),
    .edge_pulse (edge_pulse)
  );
  always_comb begin
    wr     = bus.chipselect & ~bus.write_n;
    rd     = bus.chipselect & ~bus.read_n;
    clr    = wr && bus.address == ADDR_EDGECAP ? bus.writedata : '0;
    rd_mux = bus.address == ADDR_DATA    ? (dir & data_out) | (~dir & in_sync) :
             bus.address == ADDR_DIR     ? dir :
             bus.address == ADDR_IRQMASK ? irq_mask :
             bus.address == ADDR_EDGECAP ? edge_capture : '0;
  end
  // the mux reads pre-write state, so a same-cycle read returns the old contents
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out     <= RESET_OUT;
      dir          <= RESET_DIR;
      irq_mask     <= '0;
      edge_capture <= '0;
      irq          <= 1'b0;
      bus.readdata <= '0;
    end else begin
      data_out     <= wr && bus.address == ADDR_DATA   ? bus.writedata :
                      wr && bus.address == ADDR_OUTSET ? data_out | bus.writedata :
                      wr && bus.address == ADDR_OUTCLR ? data_out & ~bus.writedata : data_out;
      dir          <= wr && bus.address == ADDR_DIR ? bus.writedata : dir;
      irq_mask     <= wr && bus.address == ADDR_IRQMASK ? bus.writedata : irq_mask;
      edge_capture <= (edge_capture & ~clr) | edge_pulse;
      irq          <= |(edge_capture & irq_mask);
      if (rd) bus.readdata <= rd_mux;
    end
  end
  assign out_port = data_out;
  assign oe_port  = dir;
endmodule
